// File: rtl/sprite_palette.sv
// sprite_palette: multi-palette colour lookup with shadow-staged, frame-atomic updates and hit flash
module sprite_palette #(
    parameter int IDX_W        = 4,
    parameter int NUM_PAL      = 4,
    parameter int CH_W         = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 8,
    localparam int PAL_W       = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
    localparam int RGB_W       = 3 * CH_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             pix_valid,
    input  logic [PAL_W-1:0] pal_sel,
    input  logic [IDX_W-1:0] color_idx,
    input  logic             frame_start,
    input  logic             wr_en,
    input  logic [PAL_W-1:0] wr_pal,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [RGB_W-1:0] wr_rgb,
    input  logic             flash_trig,
    output logic [CH_W-1:0]  VGA_R,
    output logic [CH_W-1:0]  VGA_G,
    output logic [CH_W-1:0]  VGA_B,
    output logic             out_valid,
    output logic             out_transp,
    output logic             flashing
);
    localparam int ENT = 2 ** IDX_W;
    localparam logic [PAL_W:0]   NP = NUM_PAL[PAL_W:0];
    localparam logic [IDX_W-1:0] TI = TRANSP_IDX[IDX_W-1:0];
    localparam logic [7:0]       FF = FLASH_FRAMES[7:0];

    logic [RGB_W-1:0] active    [NUM_PAL][ENT];
    logic [RGB_W-1:0] shadow    [NUM_PAL][ENT];
    logic [RGB_W-1:0] shadow_nx [NUM_PAL][ENT];
    logic             dirty;
    logic [7:0]       fcnt;
    logic             wr_ok, commit, white;
    logic [PAL_W-1:0] wp, ps;

    // 4-bit base colours widened by repeating each nibble from the MSB down
    function automatic logic [RGB_W-1:0] base(input int e);
        logic [11:0]      n;
        logic [RGB_W-1:0] r;
        n = (e == 0) ? 12'hF00 : (e == 1) ? 12'hFFF : (e == 2) ? 12'hF76 :
            (e == 3) ? 12'h0FB : (e == 4) ? 12'h00A : (e == 5) ? 12'hB0B : 12'hD00;
        r = '0;
        for (int c = 0; c < 3; c++)
            for (int b = 0; b < CH_W; b++)
                r[c*CH_W + CH_W-1-b] = n[c*4 + 3 - (b % 4)];
        return r;
    endfunction

    assign wr_ok    = wr_en && ({1'b0, wr_pal} < NP);
    assign commit   = frame_start && (dirty || wr_ok);
    assign wp       = wr_ok ? wr_pal : '0;
    assign ps       = ({1'b0, pal_sel} < NP) ? pal_sel : '0;
    assign flashing = fcnt != 8'd0;
    assign white    = flashing && fcnt[0];

    // shadow with this cycle's write merged, so a coincident write joins the commit
    always_comb begin
        shadow_nx = shadow;
        if (wr_ok) shadow_nx[wp][wr_idx] = wr_rgb;
    end

    // palette storage: writes land in shadow, whole shadow copied to active on commit
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dirty <= 1'b0;
            for (int p = 0; p < NUM_PAL; p++)
                for (int e = 0; e < ENT; e++) begin
                    shadow[p][e] <= base(e);
                    active[p][e] <= base(e);
                end
        end else begin
            shadow <= shadow_nx;
            dirty  <= !commit && (dirty || wr_ok);
            if (commit) active <= shadow_nx;
        end
    end

    // flash counter: trigger (re)loads and beats the frame decrement
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) fcnt <= 8'd0;
        else if (flash_trig) fcnt <= FF;
        else if (frame_start && flashing) fcnt <= fcnt - 8'd1;
    end

    // registered lookup: blank, transparent, flash white, then palette colour
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
            out_valid             <= 1'b0;
            out_transp            <= 1'b0;
        end else begin
            out_valid             <= pix_valid;
            out_transp            <= pix_valid && (color_idx == TI);
            {VGA_R, VGA_G, VGA_B} <= (!pix_valid || color_idx == TI) ? '0 :
                                     white ? '1 : active[ps][color_idx];
        end
    end
endmodule

// File: tb/tb_sprite_palette.sv
// tb_sprite_palette: directed checks of lookup, staged commit, range handling, flash and reset
module tb_sprite_palette;
    logic        Clk = 0, Reset_n = 0;
    logic        pix_valid = 0, frame_start = 0, wr_en = 0, flash_trig = 0;
    logic [1:0]  pal_sel = 0, wr_pal = 0;
    logic [3:0]  color_idx = 0, wr_idx = 0;
    logic [11:0] wr_rgb = 0;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        out_valid, out_transp, flashing;
    int          n_cmp = 0, n_bad = 0;

    sprite_palette #(.IDX_W(4), .NUM_PAL(3), .CH_W(4), .TRANSP_IDX(0), .FLASH_FRAMES(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .pal_sel(pal_sel),
        .color_idx(color_idx), .frame_start(frame_start), .wr_en(wr_en), .wr_pal(wr_pal),
        .wr_idx(wr_idx), .wr_rgb(wr_rgb), .flash_trig(flash_trig), .VGA_R(VGA_R),
        .VGA_G(VGA_G), .VGA_B(VGA_B), .out_valid(out_valid), .out_transp(out_transp),
        .flashing(flashing)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] rgb, input logic v, input logic t, input logic f);
        logic [14:0] obs, exp;
        obs = {VGA_R, VGA_G, VGA_B, out_valid, out_transp, flashing};
        exp = {rgb, v, t, f};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed rgb=%h v=%b t=%b f=%b expected rgb=%h v=%b t=%b f=%b",
                   tag, obs[14:3], obs[2], obs[1], obs[0], rgb, v, t, f);
        end
    endtask

    task automatic look(input logic [1:0] p, input logic [3:0] i);
        pix_valid = 1; pal_sel = p; color_idx = i;
    endtask

    initial begin
        tick(); tick();
        chk("reset", 12'h000, 0, 0, 0);
        Reset_n = 1;
        look(2, 3); tick(); chk("base_p2_i3", 12'h0FB, 1, 0, 0);
        look(2, 9); tick(); chk("base_p2_i9", 12'hD00, 1, 0, 0);
        look(2, 0); tick(); chk("base_transp", 12'h000, 1, 1, 0);
        pix_valid = 0; tick(); chk("no_valid", 12'h000, 0, 0, 0);

        wr_en = 1; wr_pal = 1; wr_idx = 2; wr_rgb = 12'h123; look(1, 2);
        tick(); wr_en = 0; chk("staged_same", 12'hF76, 1, 0, 0);
        tick(); chk("staged_hold", 12'hF76, 1, 0, 0);
        frame_start = 1; tick(); frame_start = 0; chk("commit_cycle", 12'hF76, 1, 0, 0);
        tick(); chk("committed", 12'h123, 1, 0, 0);
        look(0, 2); tick(); chk("p0_untouched", 12'hF76, 1, 0, 0);

        wr_en = 1; wr_pal = 0; wr_idx = 7; wr_rgb = 12'hABC; frame_start = 1; look(0, 7);
        tick(); wr_en = 0; frame_start = 0; chk("coinc_pre", 12'hD00, 1, 0, 0);
        tick(); chk("coinc_post", 12'hABC, 1, 0, 0);
        frame_start = 1; tick(); frame_start = 0; tick(); chk("idle_commit", 12'hABC, 1, 0, 0);
        look(1, 2); tick(); chk("idle_commit_p1", 12'h123, 1, 0, 0);

        wr_en = 1; wr_pal = 3; wr_idx = 4; wr_rgb = 12'h555; look(0, 4);
        tick(); wr_en = 0; frame_start = 1; tick(); frame_start = 0; tick();
        chk("oor_write", 12'h00A, 1, 0, 0);
        look(3, 3); tick(); chk("oor_sel_i3", 12'h0FB, 1, 0, 0);
        look(3, 7); tick(); chk("oor_sel_i7", 12'hABC, 1, 0, 0);
        look(3, 4); tick(); chk("oor_sel_i4", 12'h00A, 1, 0, 0);

        look(1, 2); flash_trig = 1; tick(); flash_trig = 0; chk("trig_cycle", 12'h123, 1, 0, 1);
        tick(); chk("flash_w3", 12'hFFF, 1, 0, 1);
        look(1, 0); tick(); chk("flash_transp", 12'h000, 1, 1, 1);
        look(1, 2); frame_start = 1; tick(); frame_start = 0; chk("fs1_old", 12'hFFF, 1, 0, 1);
        tick(); chk("flash_n2", 12'h123, 1, 0, 1);
        frame_start = 1; tick(); frame_start = 0; chk("fs2_old", 12'h123, 1, 0, 1);
        tick(); chk("flash_w1", 12'hFFF, 1, 0, 1);
        frame_start = 1; tick(); frame_start = 0; chk("fs3_old", 12'hFFF, 1, 0, 0);
        tick(); chk("flash_done", 12'h123, 1, 0, 0);
        frame_start = 1; tick(); frame_start = 0; tick(); chk("fs_idle_flash", 12'h123, 1, 0, 0);

        flash_trig = 1; frame_start = 1; tick(); flash_trig = 0; frame_start = 0;
        chk("trig_fs0", 12'h123, 1, 0, 1);
        tick(); chk("trig_fs0_w", 12'hFFF, 1, 0, 1);
        frame_start = 1; tick(); frame_start = 0; tick(); chk("dec_to2", 12'h123, 1, 0, 1);
        flash_trig = 1; frame_start = 1; tick(); flash_trig = 0; frame_start = 0;
        chk("reload_cycle", 12'h123, 1, 0, 1);
        tick(); chk("reload_3", 12'hFFF, 1, 0, 1);

        wr_en = 1; wr_pal = 1; wr_idx = 2; wr_rgb = 12'h777; tick(); wr_en = 0;
        chk("pend_flash", 12'hFFF, 1, 0, 1);
        #2 Reset_n = 0; #1;
        chk("async_reset", 12'h000, 0, 0, 0);
        tick(); Reset_n = 1;
        look(1, 2); tick(); chk("post_rst_p1", 12'hF76, 1, 0, 0);
        look(0, 7); tick(); chk("post_rst_p0", 12'hD00, 1, 0, 0);
        frame_start = 1; look(1, 2); tick(); frame_start = 0; tick();
        chk("post_rst_nodirty", 12'hF76, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_palette.md
# sprite_palette

Programmable, multi-palette colour lookup for sprite rendering. Each pixel's colour index and palette select map to registered VGA RGB outputs with one cycle of latency. Palette writes are staged in a shadow copy and committed atomically at frame start, so the screen never shows a partial update. Also provides a transparency flag and a frame-counted "hit flash" effect. Sits between the sprite ROM/address logic and the VGA output mux.

## Interface
- IDX_W, 4, colour-index width; entries per palette = 2**IDX_W
- NUM_PAL, 4, number of palettes (≥1); PAL_W = max(1, $clog2(NUM_PAL))
- CH_W, 4, bits per colour channel
- TRANSP_IDX, 0, index treated as transparent (must be < 2**IDX_W)
- FLASH_FRAMES, 8, flash duration in frames (1..255)

- Clk  in  1  system clock (pixel clock domain)
- Reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  pixel lookup request this cycle
- pal_sel  in  PAL_W  palette used for the lookup
- color_idx  in  IDX_W  colour index used for the lookup
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- wr_en  in  1  palette write strobe
- wr_pal  in  PAL_W  palette written
- wr_idx  in  IDX_W  entry written
- wr_rgb  in  3*CH_W  {R,G,B} value written
- flash_trig  in  1  one-cycle pulse that starts the hit flash
- VGA_R, VGA_G, VGA_B  out  CH_W each  registered colour
- out_valid  out  1  pix_valid delayed by one cycle
- out_transp  out  1  registered transparency flag
- flashing  out  1  high while the flash counter is non-zero

## Operation
- Storage: two arrays, active[NUM_PAL][2**IDX_W] and shadow[NUM_PAL][2**IDX_W], each entry 3*CH_W bits.
- Reset contents: every palette in both arrays is loaded with the same base table. Values are given for CH_W=4; for wider channels, each nibble is replicated MSB-first.
  - 0:F00, 1:FFF, 2:F76, 3:0FB, 4:00A, 5:B0B, all other entries D00.
- Writes: when wr_en=1, shadow[wr_pal][wr_idx] <= wr_rgb. If wr_pal ≥ NUM_PAL, the write is ignored. Each accepted write sets the internal dirty bit.
- Commit: on frame_start with dirty=1, active <= shadow (whole array) and dirty is cleared.
  - A write in the same cycle as frame_start is included in the commit, and dirty ends at 0.
  - frame_start with dirty=0 does nothing to the palettes.
- Lookup: only active is read. If pal_sel ≥ NUM_PAL, palette 0 is used.
- Output selection, registered on Clk, in priority order:
  1. pix_valid=0: RGB=0, out_transp=0.
  2. color_idx==TRANSP_IDX: RGB=0, out_transp=1.
  3. Flash white phase active: RGB all ones, out_transp=0.
  4. Otherwise: RGB = active entry, out_transp=0.
- Flash counter fcnt (8 bits):
  - flash_trig loads FLASH_FRAMES. A trigger while already flashing reloads it.
  - frame_start with fcnt≠0 decrements it.
  - flash_trig and frame_start in the same cycle: the load wins and no decrement occurs.
  - flashing = (fcnt≠0). The white phase is active when flashing=1 and fcnt[0]=1.

## Timing
- Lookup latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. Full throughput, one pixel per cycle, no stalls.
- A lookup in the commit cycle (frame_start=1) reads the pre-commit active array. Lookups from the next cycle onward see the new values.
- A write takes effect on screen at the first frame_start at or after the write, and is visible from the cycle after that frame_start.
- Flash phase changes only at the edge following flash_trig or frame_start. The output register in that same cycle still uses the old fcnt.
- Reset (async assert, any time including mid-commit or mid-flash):
  - VGA_R/G/B=0, out_valid=0, out_transp=0, flashing=0, fcnt=0, dirty=0.
  - Both arrays return to the base table.
- Deassertion is synchronous to Clk via the system reset synchroniser, which is outside this block.

## Test plan
- Reset defaults: after reset, pix_valid=1, pal_sel=2, idx=3 → next cycle RGB=0/F/B and out_valid=1. idx=9 → D/0/0. idx=0 → RGB=0 and out_transp=1.
- Staged write: write pal1 idx2=0x123 and check that lookups still return F76. Pulse frame_start; the lookup in that cycle returns F76, and the following cycle returns 1/2/3. Palette 0 idx2 still returns F76.
- Write coincident with frame_start: wr_en and frame_start in the same cycle (pal0 idx7=0xABC). From the next cycle, idx7 returns A/B/C. A second frame_start with no writes changes nothing.
- Out-of-range: with NUM_PAL=3, a write to pal 3 is ignored and dirty stays 0. A lookup with pal_sel=3 returns the palette 0 entry.
- Flash: FLASH_FRAMES=3, then flash_trig.
  - White (FFF) until the first frame_start, then normal colour, then white, then normal with flashing=0 after the 3rd frame_start.
  - Transparent pixels stay flagged throughout.
  - flash_trig coincident with frame_start reloads fcnt to 3.
- Mid-operation reset: assert Reset_n low during a flash with a pending write. Outputs go to 0 immediately; after release, lookups return base-table values and flashing=0.
